// File: rtl/nnet_pkg.sv
// Shared types and defaults for the nnet result-stream packetizer.
// Length width, FSM encoding and settings-bus defaults live here.
package nnet_pkg;

  localparam int LEN_W              = 16;
  localparam int SR_SIZE_OUTPUT_DEF = 130;
  localparam int DEFAULT_SIZE_DEF   = 16;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } pkt_state_e;

  // A programmed length of zero still yields one-beat packets.
  function automatic len_t eff_len(input len_t s);
    return (s == '0) ? len_t'(1) : s;
  endfunction

endpackage

// File: rtl/nnet_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Head word is presented combinationally on dout.
module nnet_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nnet_fifo_packetizer.sv
// Buffers an HLS ap_fifo result stream and frames it into AXI-stream
// packets of programmable length, tagged with the latched header.
module nnet_fifo_packetizer
  import nnet_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DEPTH_LOG2     = 5,
  parameter int SR_SIZE_OUTPUT = SR_SIZE_OUTPUT_DEF,
  parameter int DEFAULT_SIZE   = DEFAULT_SIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] res_din,
  input  logic             res_write,
  output logic             res_full_n,
  input  logic [127:0]     tuser_in,
  input  logic             tuser_stb,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [127:0]     o_tuser,
  output logic             overflow_err
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;

  pkt_state_e    state;
  pkt_state_e    state_nxt;
  len_t          size_reg;
  len_t          pkt_len;
  len_t          pkt_len_q;
  len_t          beat_cnt;
  len_t          beat_nxt;
  logic [127:0]  hdr_hold;
  logic [127:0]  tuser_q;
  logic          last_beat;
  logic          unused_hi;

  assign unused_hi = ^set_data[31:16];

  nnet_sync_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (res_din),
    .dout  (o_tdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign push      = res_write && res_full_n && !full && !clear;
  assign o_tvalid  = !empty;
  assign pop       = o_tvalid && o_tready;
  assign cnt_nxt   = count + CW'(push) - CW'(pop);

  // Length and header follow live settings only until the first beat goes out.
  assign pkt_len   = (state == ST_IDLE) ? eff_len(size_reg) : pkt_len_q;
  assign o_tuser   = (state == ST_IDLE) ? hdr_hold : tuser_q;
  assign last_beat = (beat_cnt == pkt_len - 1'b1);
  assign o_tlast   = o_tvalid && last_beat;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (pop && !last_beat) begin
          state_nxt = ST_BODY;
          beat_nxt  = len_t'(1);
        end
      end
      ST_BODY: begin
        if (pop) begin
          if (last_beat) begin
            state_nxt = ST_IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt  = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      pkt_len_q    <= len_t'(1);
      tuser_q      <= '0;
      size_reg     <= len_t'(DEFAULT_SIZE);
      hdr_hold     <= '0;
      res_full_n   <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      if (set_stb && set_addr == 8'(SR_SIZE_OUTPUT))
        size_reg <= set_data[15:0];
      if (tuser_stb)
        hdr_hold <= tuser_in;
      if (clear) begin
        state        <= ST_IDLE;
        beat_cnt     <= '0;
        res_full_n   <= 1'b1;
        overflow_err <= 1'b0;
      end else begin
        state      <= state_nxt;
        beat_cnt   <= beat_nxt;
        res_full_n <= (cnt_nxt != CW'(DEPTH));
        if (res_write && !res_full_n)
          overflow_err <= 1'b1;
        if (state == ST_IDLE && pop) begin
          pkt_len_q <= pkt_len;
          tuser_q   <= o_tuser;
        end
      end
    end
  end

endmodule

// File: tb/tb_nnet_fifo_packetizer.sv
// Scoreboard bench for nnet_fifo_packetizer with a 4-word FIFO.
// Expected beats are queued at write time and checked on handshake.
module tb_nnet_fifo_packetizer;

  localparam int W   = 16;
  localparam int DL2 = 2;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [W-1:0] res_din;
  logic         res_write;
  logic         res_full_n;
  logic [127:0] tuser_in;
  logic         tuser_stb;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic [127:0] o_tuser;
  logic         overflow_err;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [127:0] user;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           vectors = 0;
  int           miscompares = 0;
  int           mdl_cnt = 0;
  int           mdl_len = 16;
  logic [127:0] mdl_user = '0;
  logic [W-1:0] wdata = 16'h0100;

  localparam logic [127:0] H1 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [127:0] HA = 128'haaaa_0000_1111_2222_3333_4444_5555_aaaa;
  localparam logic [127:0] HB = 128'hbbbb_9999_8888_7777_6666_5555_4444_bbbb;

  nnet_fifo_packetizer #(
    .WIDTH      (W),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .res_din      (res_din),
    .res_write    (res_write),
    .res_full_n   (res_full_n),
    .tuser_in     (tuser_in),
    .tuser_stb    (tuser_stb),
    .o_tdata      (o_tdata),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .o_tuser      (o_tuser),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset && o_tvalid && o_tready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected got data=%h last=%b want no beat",
                 o_tdata, o_tlast);
      end else begin
        mon_e = sb.pop_front();
        if (o_tdata !== mon_e.data || o_tlast !== mon_e.last ||
            o_tuser !== mon_e.user) begin
          miscompares++;
          $display("FAIL beat got data=%h last=%b user=%h want data=%h last=%b user=%h",
                   o_tdata, o_tlast, o_tuser, mon_e.data, mon_e.last, mon_e.user);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write();
    int   t;
    logic lst;
    t = 0;
    while (res_full_n !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    if (res_full_n !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL write_wait got res_full_n=%b want 1", res_full_n);
    end else begin
      mdl_cnt++;
      lst = (mdl_cnt == mdl_len);
      if (lst) mdl_cnt = 0;
      sb.push_back('{data: wdata, last: lst, user: mdl_user});
      res_din   = wdata;
      res_write = 1'b1;
      tick();
      res_write = 1'b0;
      wdata     = wdata + 1'b1;
    end
  endtask

  task automatic set_size(input logic [31:0] v);
    set_stb  = 1'b1;
    set_addr = 8'd130;
    set_data = v;
    tick();
    set_stb  = 1'b0;
    mdl_len  = (v[15:0] == 16'd0) ? 1 : int'(v[15:0]);
  endtask

  task automatic set_hdr(input logic [127:0] h);
    tuser_stb = 1'b1;
    tuser_in  = h;
    tick();
    tuser_stb = 1'b0;
    mdl_user  = h;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tvalid got %b want 0", o_tvalid);
    end
    vectors++;
    if (o_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tlast got %b want 0", o_tlast);
    end
    vectors++;
    if (res_full_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_full_n got %b want 1", res_full_n);
    end
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overflow got %b want 0", overflow_err);
    end
    vectors++;
    if (o_tuser !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_tuser got %h want 0", o_tuser);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    o_tready = 1'b1;
    set_size(32'd4);
    set_hdr(H1);
    vectors++;
    if (o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_valid got %b want 0", o_tvalid);
    end
    do_write();
    vectors++;
    if (o_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency got tvalid=%b want 1", o_tvalid);
    end
    repeat (7) do_write();
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  task automatic test_overflow();
    o_tready = 1'b0;
    repeat (4) do_write();
    vectors++;
    if (res_full_n !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_full_n got %b want 0", res_full_n);
    end
    res_din   = 16'hdead;
    res_write = 1'b1;
    tick();
    res_write = 1'b0;
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag got %b want 1", overflow_err);
    end
    o_tready = 1'b1;
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drain got left=%0d tvalid=%b err=%b want 0 0 1",
               sb.size(), o_tvalid, overflow_err);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear got %b want 0", overflow_err);
    end
  endtask

  task automatic test_size_zero();
    o_tready = 1'b1;
    set_size(32'd0);
    repeat (3) do_write();
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  task automatic test_size_change();
    o_tready = 1'b0;
    set_size(32'd4);
    repeat (4) do_write();
    o_tready = 1'b1;
    tick();
    tick();
    o_tready = 1'b0;
    set_size(32'd2);
    vectors++;
    if (o_tvalid !== 1'b1 || o_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_mid got tvalid=%b tlast=%b want 1 0", o_tvalid, o_tlast);
    end
    o_tready = 1'b1;
    repeat (2) do_write();
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  task automatic test_back_to_back();
    o_tready = 1'b0;
    set_size(32'd7);
    repeat (4) do_write();
    vectors++;
    if (res_full_n !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full got res_full_n=%b want 0", res_full_n);
    end
    o_tready = 1'b1;
    tick();
    vectors++;
    if (res_full_n !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_pop got res_full_n=%b want 1", res_full_n);
    end
    for (int i = 0; i < 10; i++) begin
      mdl_cnt++;
      sb.push_back('{data: wdata, last: (mdl_cnt == mdl_len), user: mdl_user});
      if (mdl_cnt == mdl_len) mdl_cnt = 0;
      res_din   = wdata;
      res_write = 1'b1;
      tick();
      wdata = wdata + 1'b1;
      vectors++;
      if (res_full_n !== 1'b1 || o_tvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_steady cyc=%0d got full_n=%b tvalid=%b want 1 1",
                 i, res_full_n, o_tvalid);
      end
    end
    res_write = 1'b0;
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  task automatic test_header();
    o_tready = 1'b0;
    set_size(32'd1);
    set_hdr(HA);
    do_write();
    o_tready  = 1'b1;
    tuser_stb = 1'b1;
    tuser_in  = HB;
    tick();
    tuser_stb = 1'b0;
    o_tready  = 1'b0;
    mdl_user  = HB;
    vectors++;
    if (o_tuser !== HB) begin
      miscompares++;
      $display("FAIL hdr_next got %h want %h", o_tuser, HB);
    end
    o_tready = 1'b1;
    do_write();
    drain();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL hdr_drain got left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_clear();
    o_tready = 1'b0;
    set_size(32'd8);
    repeat (4) do_write();
    o_tready = 1'b1;
    repeat (3) tick();
    o_tready  = 1'b0;
    clear     = 1'b1;
    res_din   = 16'hbeef;
    res_write = 1'b1;
    tick();
    clear     = 1'b0;
    res_write = 1'b0;
    sb.delete();
    mdl_cnt = 0;
    vectors++;
    if (o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_valid got %b want 0", o_tvalid);
    end
    o_tready = 1'b1;
    repeat (8) do_write();
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  task automatic test_reset_mid();
    o_tready = 1'b0;
    set_size(32'd4);
    repeat (2) do_write();
    o_tready = 1'b1;
    tick();
    o_tready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    mdl_cnt  = 0;
    mdl_len  = 16;
    mdl_user = '0;
    vectors++;
    if (o_tvalid !== 1'b0 || o_tuser !== 128'd0) begin
      miscompares++;
      $display("FAIL rst_mid got tvalid=%b tuser=%h want 0 0", o_tvalid, o_tuser);
    end
    o_tready = 1'b1;
    repeat (16) do_write();
    drain();
    vectors++;
    if (sb.size() != 0 || o_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drain got left=%0d tvalid=%b want 0 0", sb.size(), o_tvalid);
    end
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    set_stb   = 1'b0;
    set_addr  = 8'd0;
    set_data  = 32'd0;
    res_din   = '0;
    res_write = 1'b0;
    tuser_in  = '0;
    tuser_stb = 1'b0;
    o_tready  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_size_zero();
    test_size_change();
    test_back_to_back();
    test_header();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
